pipeline_hazard_controller: RTL and testbench

- Hazard and sequencing controller for the five-stage pipelined CPU datapath (IF/ID/EXE/MEM/WB).
- Keeps its own scoreboard of in-flight destination registers. From it, the block drives the ID-stage forwarding selects and the load-use stall/bubble control.
- Also holds the pipeline frozen for a boot window after reset, and keeps cycle, stall and retire counters for bring-up and verification.

---
 rtl/pipeline_hazard_controller.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for a five-stage pipeline.
// It tracks in-flight destinations in E/M/W shadow stages and derives:
//   - ID-stage forwarding selects
//   - load-use stall / bubble control
//   - the post-reset boot window
//   - bring-up performance counters
module pipeline_hazard_controller #(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [4:0]       id_dest,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic             run,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES);

    // Shadow pipeline state. W is never forwarded, so only its valid bit
    // is kept (it feeds the retire counter).
    logic       e_valid_reg, e_wreg_reg, e_m2reg_reg;
    logic [4:0] e_dest_reg;
    logic       m_valid_reg, m_wreg_reg, m_m2reg_reg;
    logic [4:0] m_dest_reg;
    logic       w_valid_reg;
    logic [3:0] boot_cnt_reg;

    logic             load_use;
    logic [1:0]       fwd_sel [2];
    logic [4:0]       src_reg [2];
    logic             src_use [2];
    logic [CNT_W-1:0] cycle_cnt_reg, stall_cnt_reg, retire_cnt_reg;

    assign src_reg[0] = id_rs;
    assign src_reg[1] = id_rt;
    assign src_use[0] = id_use_rs;
    assign src_use[1] = id_use_rt;

    assign run = (boot_cnt_reg == 4'd0);

    // Load-use detection: the load in E cannot be forwarded yet.
    // A match on both rs and rt still gives a single stall.
    always_comb begin
        load_use = 1'b0;
        if (id_valid && e_valid_reg && e_wreg_reg && e_m2reg_reg && (e_dest_reg != 5'd0)) begin
            load_use = (id_use_rs && (e_dest_reg == id_rs)) ||
                       (id_use_rt && (e_dest_reg == id_rt));
        end
    end

    assign stall = !run || load_use;

    // Per-operand forwarding select.
    // Priority: E wins over M (youngest producer), and register 0 never matches.
    // Outputs are forced to regfile while the boot window is open.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = 2'd0;
                if (run && src_use[gi] && (src_reg[gi] != 5'd0)) begin
                    if (e_valid_reg && e_wreg_reg && !e_m2reg_reg && (e_dest_reg == src_reg[gi]))
                        fwd_sel[gi] = 2'd1;
                    else if (m_valid_reg && m_wreg_reg && (m_dest_reg == src_reg[gi]))
                        fwd_sel[gi] = m_m2reg_reg ? 2'd3 : 2'd2;
                end
            end
        end
    endgenerate

    assign fwda = fwd_sel[0];
    assign fwdb = fwd_sel[1];

    // Boot window countdown: run holds off until the counter drains to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            boot_cnt_reg <= BOOT_INIT;
        else if (boot_cnt_reg != 4'd0)
            boot_cnt_reg <= boot_cnt_reg - 4'd1;
    end

    // Shadow stage advance.
    // A bubble enters E whenever the pipeline is stalled or still booting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_valid_reg <= 1'b0;
            e_wreg_reg  <= 1'b0;
            e_m2reg_reg <= 1'b0;
            e_dest_reg  <= 5'd0;
            m_valid_reg <= 1'b0;
            m_wreg_reg  <= 1'b0;
            m_m2reg_reg <= 1'b0;
            m_dest_reg  <= 5'd0;
            w_valid_reg <= 1'b0;
        end else begin
            w_valid_reg <= m_valid_reg;
            m_valid_reg <= e_valid_reg;
            m_wreg_reg  <= e_wreg_reg;
            m_m2reg_reg <= e_m2reg_reg;
            m_dest_reg  <= e_dest_reg;
            if (!stall) begin
                e_valid_reg <= id_valid;
                e_wreg_reg  <= id_wreg;
                e_m2reg_reg <= id_m2reg;
                e_dest_reg  <= id_dest;
            end else begin
                e_valid_reg <= 1'b0;
                e_wreg_reg  <= 1'b0;
                e_m2reg_reg <= 1'b0;
                e_dest_reg  <= 5'd0;
            end
        end
    end

    // Performance counters; they wrap freely.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt_reg  <= '0;
            stall_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (run)
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            if (run && load_use)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (w_valid_reg)
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
        end
    end

    assign cycle_cnt  = cycle_cnt_reg;
    assign stall_cnt  = stall_cnt_reg;
    assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_wreg = 1'b0;
    logic        id_m2reg = 1'b0;
    logic [4:0]  id_dest = '0;
    logic [1:0]  fwda, fwdb;
    logic        stall, run;
    logic [31:0] cycle_cnt, stall_cnt, retire_cnt;

    int checks = 0;
    int passes = 0;

    pipeline_hazard_controller #(.BOOT_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_dest(id_dest),
        .fwda(fwda), .fwdb(fwdb), .stall(stall), .run(run),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in ID and let combinational outputs settle.
    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic ld, input logic [4:0] dst);
        id_valid = v;  id_rs = rs;     id_rt = rt;
        id_use_rs = urs; id_use_rt = urt;
        id_wreg = wr;  id_m2reg = ld;  id_dest = dst;
        #1;
        $display("ID: v=%0b rs=%0d rt=%0d use=%0b%0b wreg=%0b ld=%0b dest=%0d -> fwda=%0d fwdb=%0d stall=%0b run=%0b",
                 v, rs, rt, urs, urt, wr, ld, dst, fwda, fwdb, stall, run);
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        go();
        go();
        rstn = 1'b1;
        repeat (4) go();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        go();
        checks++;
        if (stall !== 1'b1 || run !== 1'b0 || fwda !== 2'd0 || fwdb !== 2'd0)
            $display("FAIL reset_outputs: stall=%0b run=%0b fwda=%0d fwdb=%0d, want 1 0 0 0",
                     stall, run, fwda, fwdb);
        else passes++;
        checks++;
        if (cycle_cnt !== 0 || stall_cnt !== 0 || retire_cnt !== 0)
            $display("FAIL reset_counters: %0d %0d %0d, want 0 0 0",
                     cycle_cnt, stall_cnt, retire_cnt);
        else passes++;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || run !== 1'b0)
                $display("FAIL boot_window[%0d]: stall=%0b run=%0b, want 1 0", i, stall, run);
            else passes++;
            go();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stall !== 1'b0 || run !== 1'b1 || cycle_cnt !== 32'(i))
                $display("FAIL boot_done[%0d]: stall=%0b run=%0b cycle_cnt=%0d, want 0 1 %0d",
                         i, stall, run, cycle_cnt, i);
            else passes++;
            go();
        end
    endtask

    task automatic test_forward();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);   // add r3
        checks++;
        if (fwda !== 2'd0 || fwdb !== 2'd0 || stall !== 1'b0)
            $display("FAIL fwd_first: fwda=%0d fwdb=%0d stall=%0b, want 0 0 0", fwda, fwdb, stall);
        else passes++;
        go();
        issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);   // sub r6, r3, r4
        checks++;
        if (fwda !== 2'd1 || fwdb !== 2'd0 || stall !== 1'b0)
            $display("FAIL fwd_exe: fwda=%0d fwdb=%0d stall=%0b, want 1 0 0", fwda, fwdb, stall);
        else passes++;
        go();
        issue(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);   // or r8, r1, r3
        checks++;
        if (fwda !== 2'd0 || fwdb !== 2'd2 || stall !== 1'b0)
            $display("FAIL fwd_mem: fwda=%0d fwdb=%0d stall=%0b, want 0 2 0", fwda, fwdb, stall);
        else passes++;
        go();
        checks++;
        if (stall_cnt !== 0)
            $display("FAIL fwd_no_stall: stall_cnt=%0d, want 0", stall_cnt);
        else passes++;
    endtask

    task automatic test_load_use();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);   // lw r5
        go();
        issue(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);   // add r9, r2, r5
        checks++;
        if (stall !== 1'b1)
            $display("FAIL load_use_stall: stall=%0b, want 1", stall);
        else passes++;
        go();
        checks++;
        if (stall !== 1'b0 || fwdb !== 2'd3 || fwda !== 2'd0 || stall_cnt !== 1)
            $display("FAIL load_use_after: stall=%0b fwda=%0d fwdb=%0d stall_cnt=%0d, want 0 0 3 1",
                     stall, fwda, fwdb, stall_cnt);
        else passes++;
        go();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);   // lw r5
        go();
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10);  // add r10, r5, r5
        checks++;
        if (stall !== 1'b1)
            $display("FAIL dual_stall: stall=%0b, want 1", stall);
        else passes++;
        go();
        checks++;
        if (stall !== 1'b0 || fwda !== 2'd3 || fwdb !== 2'd3 || stall_cnt !== 2)
            $display("FAIL dual_after: stall=%0b fwda=%0d fwdb=%0d stall_cnt=%0d, want 0 3 3 2",
                     stall, fwda, fwdb, stall_cnt);
        else passes++;
        go();
    endtask

    task automatic test_r0();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);   // lw r0
        go();
        issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd11);  // reader, wreg=0
        checks++;
        if (fwda !== 2'd0 || fwdb !== 2'd0 || stall !== 1'b0)
            $display("FAIL r0_exe: fwda=%0d fwdb=%0d stall=%0b, want 0 0 0", fwda, fwdb, stall);
        else passes++;
        go();
        issue(1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12); // M=lw r0, E=nowrite r11
        checks++;
        if (fwda !== 2'd0 || fwdb !== 2'd0 || stall !== 1'b0)
            $display("FAIL r0_mem_nowreg: fwda=%0d fwdb=%0d stall=%0b, want 0 0 0", fwda, fwdb, stall);
        else passes++;
        go();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);   // add r7
        go();
        issue(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);   // addi r7, r7
        go();
        issue(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12);
        checks++;
        if (fwda !== 2'd1 || fwdb !== 2'd1 || stall !== 1'b0)
            $display("FAIL b2b_youngest: fwda=%0d fwdb=%0d stall=%0b, want 1 1 0", fwda, fwdb, stall);
        else passes++;
        go();
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 1'b1, 1'b0, 5'(13 + i));
            go();
        end
        idle();
        go();
        go();
        checks++;
        if (retire_cnt !== 9)
            $display("FAIL retire_partial: retire_cnt=%0d, want 9", retire_cnt);
        else passes++;
        go();
        checks++;
        if (retire_cnt !== 10)
            $display("FAIL retire_all: retire_cnt=%0d, want 10", retire_cnt);
        else passes++;
    endtask

    task automatic test_mid_reset();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);   // lw r5
        go();
        issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || run !== 1'b0 || fwda !== 2'd0 || fwdb !== 2'd0)
            $display("FAIL midreset_outputs: stall=%0b run=%0b fwda=%0d fwdb=%0d, want 1 0 0 0",
                     stall, run, fwda, fwdb);
        else passes++;
        checks++;
        if (cycle_cnt !== 0 || stall_cnt !== 0 || retire_cnt !== 0)
            $display("FAIL midreset_counters: %0d %0d %0d, want 0 0 0",
                     cycle_cnt, stall_cnt, retire_cnt);
        else passes++;
        idle();
        go();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || run !== 1'b0)
                $display("FAIL reboot_window[%0d]: stall=%0b run=%0b, want 1 0", i, stall, run);
            else passes++;
            go();
        end
        checks++;
        if (run !== 1'b1 || stall !== 1'b0 || retire_cnt !== 0)
            $display("FAIL reboot_done: run=%0b stall=%0b retire_cnt=%0d, want 1 0 0",
                     run, stall, retire_cnt);
        else passes++;
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        go();
        idle();
        go();
        go();
        go();
        checks++;
        if (retire_cnt !== 1)
            $display("FAIL reboot_retire: retire_cnt=%0d, want 1", retire_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_r0();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
